exec_unit: RTL and testbench
============================

# exec_unit

Execute stage of the 8-bit RISC core. Sits between operand fetch and writeback: it consumes the two operands read from the 64-entry register file along with a decoded opcode and destination index. It produces a single-cycle write request (wr_en/wr_addr/wr_data) that drives the register file write port directly. Single-cycle ALU ops use one cycle; MUL is an iterative shift-add that takes DATA_WIDTH cycles and back-pressures issue through in_ready.

## Interface

- DATA_WIDTH, 8, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  issue request, qualified by in_ready
- in_ready  out  1  high when the stage can accept an op (state IDLE)
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL, 8 PASS; 9-15 illegal
- rd  in  6  destination register index
- rs1_data  in  DATA_WIDTH  operand A (register file read port 1)
- rs2_data  in  DATA_WIDTH  operand B (register file read port 2)
- wr_en  out  1  register file write enable, one-cycle pulse per completed op
- wr_addr  out  6  register file write index
- wr_data  out  DATA_WIDTH  register file write data
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow/overflow flag
- err  out  1  one-cycle pulse on illegal opcode

## Operation

- Accept occurs when in_valid && in_ready at a rising edge. Inputs are sampled only at accept.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0.
  - IDLE -> MUL on accept with op=7.
  - MUL -> IDLE after the DATA_WIDTH-th step.
  - All other accepts stay in IDLE.
- ADD: result=A+B mod 2^W; C = bit W of the sum.
- SUB: result=A-B mod 2^W; C = (A<B) unsigned borrow.
- AND/OR/XOR are bitwise; C unchanged.
- SLL/SRL shift A by B[2:0] (0-7), zero fill; C unchanged.
- PASS: result=B; C unchanged.
- MUL: unsigned A*B, full 2W-bit product computed by shift-add, one multiplier bit per cycle.
  - result = low W bits.
  - C = 1 iff high W bits are nonzero.
- Z = (result==0). Z updates on every legal completed op.
- rd==0: wr_en stays 0, but flags still update.
- Illegal op:
  - Accepted in one cycle.
  - No write; flags unchanged.
  - err pulses.
- wr_addr/wr_data hold their last value when wr_en=0.

## Timing

- Reset values: state IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, flag_z=0, flag_c=0, err=0. Inputs are ignored in any cycle where rst=1.
- Single-cycle op accepted at edge N:
  - wr_en/wr_addr/wr_data/err/flags valid in the cycle following edge N.
  - The register file commits at edge N+1.
- Back-to-back single-cycle ops accepted on consecutive edges produce consecutive wr_en pulses with no bubble.
- MUL accepted at edge N:
  - Steps occur at edges N+1..N+W.
  - wr_en is high in the cycle after edge N+W.
  - in_ready is low from after edge N until edge N+W. It is high again in the wr_en cycle, so the next op may be accepted at edge N+W+1.
- No forwarding is provided. Upstream must not issue an op reading a register whose write is still pending (in flight or in its wr_en cycle).
- rst during MUL:
  - Aborts the operation; no wr_en.
  - All outputs return to reset values at that edge.
- rst coincident with an accept: the accept is discarded.

## Test plan

- Arithmetic flags:
  - ADD A=0xF0, B=0x20, rd=3 -> next cycle wr_en=1, wr_addr=3, wr_data=0x10, C=1, Z=0.
  - SUB A=0x05, B=0x05 -> 0x00, Z=1, C=0.
  - SUB A=0x03, B=0x05 -> 0xFE, C=1.
- MUL latency and overflow:
  - 0x0D*0x0B, rd=7 -> in_ready low 8 cycles; wr_en exactly 9th cycle after accept; wr_data=0x8F, C=0.
  - 0x10*0x10 -> wr_data=0x00, C=1, Z=1.
  - in_valid held high throughout is not accepted until in_ready returns.
- Back-to-back issue: ADD r1, then XOR r2 (0xAA^0xFF) on consecutive edges -> two consecutive wr_en cycles, wr_addr 1 then 2, second wr_data=0x55.
- rd=0 and shifts:
  - ADD 0x01+0xFF to rd=0 -> wr_en stays 0; Z=1, C=1.
  - SLL 0x81 by B=0x09 -> shift amount 1, result 0x02.
- Reset mid-MUL: assert rst for one cycle 4 cycles after a MUL accept -> no wr_en ever for that op; in_ready=1 and all outputs at reset values next cycle; a following ADD completes normally.
- Illegal op 0xC with rd=5 -> err pulses 1 cycle, wr_en=0, flags unchanged, in_ready stays 1.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage of the 8-bit RISC core: single-cycle ALU ops plus an iterative
// shift-add multiplier, producing one register-file write request per completed op.
module exec_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [5:0]            rd,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  wr_en,
    output logic [5:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;

    localparam int              CW       = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                    r_state;
    logic                      r_ready;
    logic                      r_wr_en;
    logic [5:0]                r_wr_addr;
    logic [DATA_WIDTH-1:0]     r_wr_data;
    logic                      r_flag_z;
    logic                      r_flag_c;
    logic                      r_err;
    logic [2*DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH-1:0]     r_mplier;
    logic [2*DATA_WIDTH-1:0]   r_prod;
    logic [CW-1:0]             r_cnt;
    logic [5:0]                r_rd;

    logic                      w_accept;
    logic [DATA_WIDTH:0]       w_sum;
    logic [DATA_WIDTH:0]       w_diff;
    logic [DATA_WIDTH-1:0]     w_res;
    logic                      w_c_new;
    logic                      w_legal;
    logic [2*DATA_WIDTH-1:0]   w_addend;
    logic [2*DATA_WIDTH-1:0]   w_prod_next;

    assign in_ready = r_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign flag_z   = r_flag_z;
    assign flag_c   = r_flag_c;
    assign err      = r_err;

    assign w_accept    = in_valid && r_ready;
    assign w_sum       = {1'b0, rs1_data} + {1'b0, rs2_data};
    assign w_diff      = {1'b0, rs1_data} - {1'b0, rs2_data};
    assign w_addend    = r_mplier[0] ? r_mcand : {(2*DATA_WIDTH){1'b0}};
    assign w_prod_next = r_prod + w_addend;

    // Single-cycle ALU result and carry; logical ops and PASS keep the old carry.
    always_comb begin
        w_res   = {DATA_WIDTH{1'b0}};
        w_c_new = r_flag_c;
        w_legal = 1'b1;
        case (op)
            OP_ADD: begin
                w_res   = w_sum[DATA_WIDTH-1:0];
                w_c_new = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                w_res   = w_diff[DATA_WIDTH-1:0];
                w_c_new = w_diff[DATA_WIDTH];
            end
            OP_AND:  w_res = rs1_data & rs2_data;
            OP_OR:   w_res = rs1_data | rs2_data;
            OP_XOR:  w_res = rs1_data ^ rs2_data;
            OP_SLL:  w_res = rs1_data << rs2_data[2:0];
            OP_SRL:  w_res = rs1_data >> rs2_data[2:0];
            OP_MUL:  w_res = {DATA_WIDTH{1'b0}};
            OP_PASS: w_res = rs2_data;
            default: w_legal = 1'b0;
        endcase
    end

    // Issue control, multiplier iteration and registered write/flag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 6'd0;
            r_wr_data <= {DATA_WIDTH{1'b0}};
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
            r_err     <= 1'b0;
            r_mcand   <= {(2*DATA_WIDTH){1'b0}};
            r_mplier  <= {DATA_WIDTH{1'b0}};
            r_prod    <= {(2*DATA_WIDTH){1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_rd      <= 6'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op == OP_MUL) begin
                            r_state  <= S_MUL;
                            r_ready  <= 1'b0;
                            r_mcand  <= {{DATA_WIDTH{1'b0}}, rs1_data};
                            r_mplier <= rs2_data;
                            r_prod   <= {(2*DATA_WIDTH){1'b0}};
                            r_cnt    <= {CW{1'b0}};
                            r_rd     <= rd;
                        end else if (w_legal) begin
                            r_flag_z <= (w_res == {DATA_WIDTH{1'b0}});
                            r_flag_c <= w_c_new;
                            if (rd != 6'd0) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= rd;
                                r_wr_data <= w_res;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    // The last step folds its partial product straight into the outputs.
                    if (r_cnt == LAST_STEP) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_flag_z <= (w_prod_next[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
                        r_flag_c <= |w_prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
                        if (r_rd != 6'd0) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_rd;
                            r_wr_data <= w_prod_next[DATA_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: per-feature tasks with inline checks plus a
// write scoreboard that matches every wr_en pulse against queued expectations.
module tb_exec_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [5:0] rd;
    logic [7:0] rs1_data;
    logic [7:0] rs2_data;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       flag_z;
    logic       flag_c;
    logic       err;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
        logic       z;
        logic       c;
    } wr_exp_t;

    wr_exp_t sb[$];
    int total = 0;
    int bad   = 0;

    exec_unit #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
            end else begin
                wr_exp_t e;
                e = sb.pop_front();
                if ({wr_addr, wr_data, flag_z, flag_c} !== {e.addr, e.data, e.z, e.c}) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%0d data=%h z=%b c=%b, expected addr=%0d data=%h z=%b c=%b",
                             wr_addr, wr_data, flag_z, flag_c, e.addr, e.data, e.z, e.c);
                end
            end
        end
    end

    task automatic set_op(input logic [3:0] o, input logic [5:0] d,
                          input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        op       = o;
        rd       = d;
        rs1_data = a;
        rs2_data = b;
    endtask

    // Issue one op on the next edge and return at the negedge where its result is visible.
    task automatic issue1(input logic [3:0] o, input logic [5:0] d,
                          input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        set_op(o, d, a, b);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [5:0] a, input logic [7:0] d, input logic z, input logic c);
        wr_exp_t e;
        e.addr = a; e.data = d; e.z = z; e.c = c;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_op(4'd0, 6'd1, 8'h11, 8'h22);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({in_ready, wr_en, wr_addr, wr_data, flag_z, flag_c, err} !== {1'b1, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b en=%b addr=%0d data=%h z=%b c=%b err=%b, expected 1 0 0 00 0 0 0",
                     in_ready, wr_en, wr_addr, wr_data, flag_z, flag_c, err);
        end
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard: got wr_en=%b, expected 0", wr_en);
        end
    endtask

    task automatic test_arith;
        push(6'd3, 8'h10, 1'b0, 1'b1);
        issue1(4'd0, 6'd3, 8'hF0, 8'h20);
        total++;
        if ({wr_en, wr_addr, flag_c, flag_z} !== {1'b1, 6'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL add_carry: got en=%b addr=%0d c=%b z=%b, expected 1 3 1 0", wr_en, wr_addr, flag_c, flag_z);
        end
        push(6'd4, 8'h00, 1'b1, 1'b0);
        issue1(4'd1, 6'd4, 8'h05, 8'h05);
        total++;
        if ({flag_z, flag_c} !== 2'b10) begin
            bad++;
            $display("FAIL sub_zero: got z=%b c=%b, expected z=1 c=0", flag_z, flag_c);
        end
        push(6'd5, 8'hFE, 1'b0, 1'b1);
        issue1(4'd1, 6'd5, 8'h03, 8'h05);
        total++;
        if ({wr_data, flag_c} !== {8'hFE, 1'b1}) begin
            bad++;
            $display("FAIL sub_borrow: got data=%h c=%b, expected FE 1", wr_data, flag_c);
        end
    endtask

    task automatic test_mul;
        int waited;
        @(negedge clk);
        set_op(4'd7, 6'd7, 8'h0D, 8'h0B);
        push(6'd7, 8'h8F, 1'b0, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // held request that must wait for in_ready
                set_op(4'd0, 6'd9, 8'h01, 8'h02);
                push(6'd9, 8'h03, 1'b0, 1'b0);
            end
            total++;
            if ({in_ready, wr_en} !== 2'b00) begin
                bad++;
                $display("FAIL mul_busy: cycle %0d got rdy=%b en=%b, expected 0 0", i + 1, in_ready, wr_en);
            end
        end
        @(negedge clk);
        total++;
        if ({wr_en, in_ready, wr_addr, wr_data, flag_c} !== {1'b1, 1'b1, 6'd7, 8'h8F, 1'b0}) begin
            bad++;
            $display("FAIL mul_done: got en=%b rdy=%b addr=%0d data=%h c=%b, expected 1 1 7 8F 0",
                     wr_en, in_ready, wr_addr, wr_data, flag_c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd9, 8'h03}) begin
            bad++;
            $display("FAIL mul_held_issue: got en=%b addr=%0d data=%h, expected 1 9 03", wr_en, wr_addr, wr_data);
        end
        push(6'd8, 8'h00, 1'b1, 1'b1);
        issue1(4'd7, 6'd8, 8'h10, 8'h10);
        waited = 0;
        while (wr_en !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if ({wr_en, wr_data, flag_c, flag_z} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL mul_overflow: got en=%b data=%h c=%b z=%b after %0d, expected 1 00 1 1",
                     wr_en, wr_data, flag_c, flag_z, waited);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_op(4'd0, 6'd1, 8'h11, 8'h22);
        push(6'd1, 8'h33, 1'b0, 1'b0);
        push(6'd2, 8'h55, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        set_op(4'd4, 6'd2, 8'hAA, 8'hFF);
        @(negedge clk);
        total++;
        if ({wr_en, wr_addr} !== {1'b1, 6'd1}) begin
            bad++;
            $display("FAIL b2b_first: got en=%b addr=%0d, expected 1 1", wr_en, wr_addr);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd2, 8'h55}) begin
            bad++;
            $display("FAIL b2b_second: got en=%b addr=%0d data=%h, expected 1 2 55", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_rd0_shift;
        issue1(4'd0, 6'd0, 8'h01, 8'hFF);
        total++;
        if ({wr_en, flag_z, flag_c} !== 3'b011) begin
            bad++;
            $display("FAIL rd0_flags: got en=%b z=%b c=%b, expected 0 1 1", wr_en, flag_z, flag_c);
        end
        push(6'd6, 8'h02, 1'b0, 1'b1);
        issue1(4'd5, 6'd6, 8'h81, 8'h09);
        total++;
        if ({wr_data, flag_c} !== {8'h02, 1'b1}) begin
            bad++;
            $display("FAIL sll_amount: got data=%h c=%b, expected 02 1", wr_data, flag_c);
        end
        push(6'd10, 8'h08, 1'b0, 1'b1);
        issue1(4'd6, 6'd10, 8'h81, 8'h0C);
        total++;
        if (wr_data !== 8'h08) begin
            bad++;
            $display("FAIL srl_amount: got data=%h, expected 08", wr_data);
        end
    endtask

    task automatic test_reset_mid_mul;
        @(negedge clk);
        set_op(4'd7, 6'd11, 8'h0D, 8'h0B);
        @(posedge clk);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({in_ready, wr_en, wr_addr, wr_data, flag_z, flag_c, err} !== {1'b1, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mul_abort: got rdy=%b en=%b addr=%0d data=%h z=%b c=%b err=%b, expected 1 0 0 00 0 0 0",
                     in_ready, wr_en, wr_addr, wr_data, flag_z, flag_c, err);
        end
        repeat (10) @(negedge clk);
        push(6'd12, 8'h05, 1'b0, 1'b0);
        issue1(4'd0, 6'd12, 8'h02, 8'h03);
        total++;
        if ({wr_en, wr_addr} !== {1'b1, 6'd12}) begin
            bad++;
            $display("FAIL post_reset_add: got en=%b addr=%0d, expected 1 12", wr_en, wr_addr);
        end
    endtask

    task automatic test_illegal;
        push(6'd13, 8'hFE, 1'b0, 1'b1);
        issue1(4'd1, 6'd13, 8'h03, 8'h05);
        issue1(4'hC, 6'd5, 8'h00, 8'h00);
        total++;
        if ({err, wr_en, flag_z, flag_c, in_ready} !== 5'b10011) begin
            bad++;
            $display("FAIL illegal_op: got err=%b en=%b z=%b c=%b rdy=%b, expected 1 0 0 1 1",
                     err, wr_en, flag_z, flag_c, in_ready);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pulse: got err=%b, expected 0", err);
        end
    endtask

    initial begin
        in_valid = 1'b0; op = 4'd0; rd = 6'd0; rs1_data = 8'd0; rs2_data = 8'd0; rst = 1'b1;
        test_reset;
        test_arith;
        test_mul;
        test_back_to_back;
        test_rd0_shift;
        test_reset_mid_mul;
        test_illegal;
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d writes outstanding, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
